// File: rtl/iopad_pkg.sv
// rtl/iopad_pkg.sv - shared state encoding and counter width for the pad bank
package iopad_pkg;

    typedef enum logic [1:0] {
        ST_IN       = 2'd0,
        ST_TURN_OUT = 2'd1,
        ST_OUT      = 2'd2,
        ST_TURN_IN  = 2'd3
    } pad_state_e;

    localparam int TURN_CNT_W = 4;

endpackage

// File: rtl/iopad_channel.sv
// rtl/iopad_channel.sv - one pad: direction FSM, turnaround counter, synchroniser, tri-state driver
module iopad_channel
    import iopad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TURN_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic zin,
    input  logic direction,
    input  logic dout,
    output logic din,
    inout  wire  pad,
    output logic oe,
    output logic busy
);

    // Counter reload value; a zero gap bypasses the turnaround states entirely.
    localparam bit                    HAS_GAP   = (TURN_CYCLES > 0);
    localparam logic [TURN_CNT_W-1:0] TURN_LOAD = TURN_CNT_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

    pad_state_e              r_state;
    pad_state_e              w_next_state;
    logic [TURN_CNT_W-1:0]   r_cnt;
    logic [TURN_CNT_W-1:0]   w_next_cnt;
    logic                    r_oe;
    logic                    r_dout;
    logic                    r_din;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    w_want_out;

    // zin is folded in here so it behaves exactly like an input-mode request.
    assign w_want_out = !direction && !zin;

    // Next-state and counter logic; a turn-in gap always runs to completion.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            ST_IN: begin
                if (w_want_out) begin
                    if (HAS_GAP) begin
                        w_next_state = ST_TURN_OUT;
                        w_next_cnt   = TURN_LOAD;
                    end else begin
                        w_next_state = ST_OUT;
                    end
                end
            end
            ST_TURN_OUT: begin
                if (!w_want_out) begin
                    w_next_state = ST_IN;
                end else if (r_cnt == '0) begin
                    w_next_state = ST_OUT;
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end
            ST_OUT: begin
                if (!w_want_out) begin
                    if (HAS_GAP) begin
                        w_next_state = ST_TURN_IN;
                        w_next_cnt   = TURN_LOAD;
                    end else begin
                        w_next_state = ST_IN;
                    end
                end
            end
            ST_TURN_IN: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_IN;
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end
            default: w_next_state = ST_IN;
        endcase
    end

    // State, counter and driver enable; oe is registered from next state so it tracks OUT exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IN;
            r_cnt   <= '0;
            r_oe    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_oe    <= (w_next_state == ST_OUT);
        end
    end

    // Output data register and the held copy of din used outside IN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout <= 1'b0;
            r_din  <= 1'b0;
        end else begin
            r_dout <= dout;
            r_din  <= din;
        end
    end

    // Free-running input synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= pad;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // din follows the last sync flop only in IN, so latency equals the chain depth.
    assign din  = (r_state == ST_IN) ? r_sync[SYNC_STAGES-1] : r_din;
    assign oe   = r_oe;
    assign busy = (r_state == ST_TURN_OUT) || (r_state == ST_TURN_IN);
    assign pad  = r_oe ? r_dout : 1'bz;

endmodule

// File: rtl/iopad_bank.sv
// rtl/iopad_bank.sv - bank of independent bidirectional pad channels
module iopad_bank #(
    parameter int NUM_PADS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TURN_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PADS-1:0] zin,
    input  logic [NUM_PADS-1:0] direction,
    input  logic [NUM_PADS-1:0] dout,
    output logic [NUM_PADS-1:0] din,
    inout  wire  [NUM_PADS-1:0] pad,
    output logic [NUM_PADS-1:0] oe,
    output logic [NUM_PADS-1:0] busy
);

    for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
        iopad_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .TURN_CYCLES (TURN_CYCLES)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .zin       (zin[g]),
            .direction (direction[g]),
            .dout      (dout[g]),
            .din       (din[g]),
            .pad       (pad[g]),
            .oe        (oe[g]),
            .busy      (busy[g])
        );
    end

endmodule
